// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit beside the EX ALU.
// Optional: define MULDIV_EARLY_OUT_EN for one-cycle |divisor| > |dividend|.
module ex_muldiv_unit #(
   parameter int XLEN        = 32,
   parameter int MUL_LATENCY = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic [4:0]      rd_addr_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] rd_data_o,
   output logic [4:0]      rd_addr_o,
   output logic            rd_write_enable_o
);

   localparam int CW = $clog2(XLEN + MUL_LATENCY + 1);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]      r_state;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_f3;
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_q;
   logic [XLEN-1:0] r_r;
   logic [XLEN-1:0] r_b;
   logic            r_negq;
   logic            r_negr;
   logic            r_done;
   logic [XLEN-1:0] r_data;
   logic [4:0]      r_addr;

   logic            w_sgn_in;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_mag_a;
   logic [XLEN-1:0] w_mag_b;
   logic            w_div0;
   logic            w_ovf;
   logic            w_early;

   assign w_sgn_in = ~funct3_i[0];
   assign w_a_neg  = w_sgn_in & rs1_data_i[XLEN-1];
   assign w_b_neg  = w_sgn_in & rs2_data_i[XLEN-1];
   assign w_mag_a  = w_a_neg ? -rs1_data_i : rs1_data_i;
   assign w_mag_b  = w_b_neg ? -rs2_data_i : rs2_data_i;
   assign w_div0   = (rs2_data_i == '0);
   assign w_ovf    = w_sgn_in & (rs1_data_i == MIN_NEG) & (&rs2_data_i);

`ifdef MULDIV_EARLY_OUT_EN
   assign w_early  = (w_mag_b > w_mag_a);
`else
   assign w_early  = 1'b0;
`endif

   // Product of sign-extended operands; truncation to 2*XLEN is exact.
   logic              w_sa;
   logic              w_sb;
   logic [2*XLEN-1:0] w_ma;
   logic [2*XLEN-1:0] w_mb;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_mul_res;

   assign w_sa      = (r_f3 == 2'b01) | (r_f3 == 2'b10);
   assign w_sb      = (r_f3 == 2'b01);
   assign w_ma      = {{XLEN{w_sa & r_q[XLEN-1]}}, r_q};
   assign w_mb      = {{XLEN{w_sb & r_b[XLEN-1]}}, r_b};
   assign w_prod    = w_ma * w_mb;
   assign w_mul_res = (r_f3 == 2'b00) ? w_prod[XLEN-1:0]
                                      : w_prod[2*XLEN-1:XLEN];

   // One restoring step: shift in the next dividend bit, try subtract.
   logic [XLEN:0]   w_rem_sh;
   logic [XLEN:0]   w_diff;
   logic            w_qbit;
   logic [XLEN-1:0] w_q_fix;
   logic [XLEN-1:0] w_r_fix;

   assign w_rem_sh = {r_r, r_q[XLEN-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_b};
   assign w_qbit   = ~w_diff[XLEN];
   assign w_q_fix  = r_negq ? -r_q : r_q;
   assign w_r_fix  = r_negr ? -r_r : r_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_f3    <= '0;
         r_rd    <= '0;
         r_q     <= '0;
         r_r     <= '0;
         r_b     <= '0;
         r_negq  <= 1'b0;
         r_negr  <= 1'b0;
         r_done  <= 1'b0;
         r_data  <= '0;
         r_addr  <= '0;
      end else begin
         r_done <= 1'b0;
         if (flush_i) begin
            r_state <= S_IDLE;
         end else begin
            unique case (r_state)
               S_IDLE: if (start_i) begin
                  r_f3 <= funct3_i[1:0];
                  r_rd <= rd_addr_i;
                  if (!funct3_i[2]) begin
                     r_state <= S_MUL;
                     r_q     <= rs1_data_i;
                     r_b     <= rs2_data_i;
                     r_cnt   <= CW'(MUL_LATENCY - 1);
                  end else begin
                     r_cnt  <= CW'(XLEN - 1);
                     r_b    <= w_mag_b;
                     r_negq <= 1'b0;
                     r_negr <= 1'b0;
                     if (w_div0) begin
                        r_state <= S_FIX;
                        r_q     <= '1;
                        r_r     <= rs1_data_i;
                     end else if (w_ovf) begin
                        r_state <= S_FIX;
                        r_q     <= rs1_data_i;
                        r_r     <= '0;
                     end else if (w_early) begin
                        r_state <= S_FIX;
                        r_q     <= '0;
                        r_r     <= rs1_data_i;
                     end else begin
                        r_state <= S_DIV;
                        r_q     <= w_mag_a;
                        r_r     <= '0;
                        r_negq  <= w_a_neg ^ w_b_neg;
                        r_negr  <= w_a_neg;
                     end
                  end
               end
               S_MUL: begin
                  if (r_cnt == '0) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                     r_data  <= w_mul_res;
                     r_addr  <= r_rd;
                  end else begin
                     r_cnt <= r_cnt - CW'(1);
                  end
               end
               S_DIV: begin
                  r_q <= {r_q[XLEN-2:0], w_qbit};
                  r_r <= w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
                  if (r_cnt == '0) r_state <= S_FIX;
                  else r_cnt <= r_cnt - CW'(1);
               end
               S_FIX: begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
                  r_data  <= r_f3[1] ? w_r_fix : w_q_fix;
                  r_addr  <= r_rd;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign busy_o            = (r_state != S_IDLE);
   assign done_o            = r_done;
   assign rd_data_o         = r_data;
   assign rd_addr_o         = r_addr;
   assign rd_write_enable_o = r_done & (r_addr != 5'd0);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit (XLEN=32, MUL_LATENCY=2).
// Expected results are queued at issue and checked when done_o pulses.
module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [2:0]  funct3_i;
   logic [31:0] rs1_data_i;
   logic [31:0] rs2_data_i;
   logic [4:0]  rd_addr_i;
   logic        flush_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] rd_data_o;
   logic [4:0]  rd_addr_o;
   logic        rd_write_enable_o;

   ex_muldiv_unit #(.XLEN(32), .MUL_LATENCY(2)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .funct3_i(funct3_i),
      .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .rd_addr_i(rd_addr_i), .flush_i(flush_i), .busy_o(busy_o),
      .done_o(done_o), .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o),
      .rd_write_enable_o(rd_write_enable_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] data;
      logic [4:0]  addr;
      logic        we;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int EO_LAT = 1;
`else
   localparam int EO_LAT = 33;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done_o) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: data %h addr %0d at cycle %0d",
                     rd_data_o, rd_addr_o, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (rd_data_o !== e.data || rd_addr_o !== e.addr ||
                rd_write_enable_o !== e.we || cyc != e.cyc ||
                busy_o !== 1'b0) begin
               errors++;
               $display("FAIL %s: data %h exp %h addr %0d exp %0d we %b exp %b cyc %0d exp %0d busy %b exp 0",
                        e.name, rd_data_o, e.data, rd_addr_o, e.addr,
                        rd_write_enable_o, e.we, cyc, e.cyc, busy_o);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h exp %h", name, act, exp);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy_o) return;
      end
      chk("idle_timeout", 32'(busy_o), 32'd0);
   endtask

   // Caller is positioned at a negedge with the unit able to accept.
   task automatic issue(input string name, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp,
                        input int lat, input bit push);
      exp_t e;
      start_i    = 1'b1;
      funct3_i   = f3;
      rs1_data_i = a;
      rs2_data_i = b;
      rd_addr_i  = rd;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      if (push) begin
         e.name = name;
         e.data = exp;
         e.addr = rd;
         e.we   = (rd != 5'd0);
         e.cyc  = cyc + lat;
         q.push_back(e);
      end
   endtask

   task automatic run(input string name, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] exp,
                      input int lat);
      wait_idle();
      issue(name, f3, a, b, rd, exp, lat, 1'b1);
   endtask

   initial begin
      int n;
      rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
      funct3_i = '0; rs1_data_i = '0; rs2_data_i = '0; rd_addr_i = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_data", rd_data_o, 32'd0);
      chk("rst_addr", 32'(rd_addr_o), 32'd0);
      chk("rst_we", 32'(rd_write_enable_o), 32'd0);

      run("mulh", 3'b001, 32'hFFFFFFFF, 32'h2, 5'd5, 32'hFFFFFFFF, 2);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!busy_o) break;
         n++;
      end
      chk("mulh_busy_cycles", 32'(n), 32'd2);

      run("div_neg", 3'b100, 32'hFFFFFFF9, 32'h2, 5'd7, 32'hFFFFFFFD, 33);
      run("rem_neg", 3'b110, 32'hFFFFFFF9, 32'h2, 5'd8, 32'hFFFFFFFF, 33);
      run("divu_0", 3'b101, 32'd100, 32'h0, 5'd9, 32'hFFFFFFFF, 1);
      run("remu_0", 3'b111, 32'd100, 32'h0, 5'd9, 32'd100, 1);
      run("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd10,
          32'h80000000, 1);
      run("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h0, 1);
      run("div_negb", 3'b100, 32'd20, 32'hFFFFFFFD, 5'd15, 32'hFFFFFFFA, 33);
      run("rem_negb", 3'b110, 32'd20, 32'hFFFFFFFD, 5'd16, 32'd2, 33);
      run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'h2, 5'd17, 32'hFFFFFFFF, 2);

      wait_idle();
      issue("divu_flushed", 3'b101, 32'd1000, 32'd3, 5'd3, 32'd0, 0, 1'b0);
      repeat (10) @(negedge clk);
      flush_i = 1'b1;
      @(posedge clk);
      #1 flush_i = 1'b0;
      @(negedge clk);
      chk("flush_busy", 32'(busy_o), 32'd0);
      repeat (40) @(negedge clk);
      run("mul_after_flush", 3'b000, 32'd3, 32'd4, 5'd11, 32'd12, 2);

      wait_idle();
      start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'b000;
      rs1_data_i = 32'd9; rs2_data_i = 32'd9; rd_addr_i = 5'd4;
      @(posedge clk);
      #1 start_i = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      chk("flush_start_busy", 32'(busy_o), 32'd0);

      run("mul_rd0", 3'b000, 32'd6, 32'd7, 5'd0, 32'd42, 2);
      n = 0;
      while (!done_o && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_done_seen", 32'(done_o), 32'd1);
      issue("mulhu_b2b", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12,
            32'hFFFFFFFE, 2, 1'b1);

      run("divu_small", 3'b101, 32'd5, 32'd9, 5'd13, 32'd0, EO_LAT);
      run("remu_small", 3'b111, 32'd5, 32'd9, 5'd14, 32'd5, EO_LAT);

      wait_idle();
      issue("divu_reset", 3'b101, 32'd50, 32'd7, 5'd6, 32'd0, 0, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_busy", 32'(busy_o), 32'd0);
      chk("rst_mid_done", 32'(done_o), 32'd0);
      repeat (40) @(negedge clk);
      run("divu_after_rst", 3'b101, 32'd50, 32'd7, 5'd18, 32'd7, 33);

      wait_idle();
      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
